// File: rtl/ts_fifo_mux_reader.sv
// ts_fifo_mux_reader
//   Read-domain consumer of four asynchronous FIFO channels (single clock rclk).
//   Each channel byte stream is aligned to TS packets (SYNC_BYTE, PKT_LEN bytes)
//   and stored in a per-channel single-packet buffer. Complete packets are
//   merged round-robin into one framed valid/ready byte stream. A channel whose
//   buffer is still occupied when a new packet starts drops that whole packet.
//
//   Optional feature macro: QOS_STATS_EN
//     defined   -> drop_cnt1..drop_cnt4 ports exist (saturating drop counters)
//     undefined -> no counter ports; dropped packets are discarded silently
//
// Ports:
//   rclk, rrst                read-domain clock, synchronous active-high reset
//   rdata1..4, valid_out1..4  channel bytes and byte-valids (no backpressure)
//   out_data, out_valid       merged byte stream
//   out_ready                 downstream accept (transfer on out_valid & out_ready)
//   out_sop, out_eop          first / last byte of a packet
//   out_ch                    source channel (0..3) of the current packet
//   drop_cnt1..4              dropped-packet counters (QOS_STATS_EN only)
module ts_fifo_mux_reader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(8'h47),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] rdata2,
    input  logic [DATA_WIDTH-1:0] rdata3,
    input  logic [DATA_WIDTH-1:0] rdata4,
    input  logic                  valid_out1,
    input  logic                  valid_out2,
    input  logic                  valid_out3,
    input  logic                  valid_out4,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
`ifdef QOS_STATS_EN
    output logic [CNT_WIDTH-1:0]  drop_cnt1,
    output logic [CNT_WIDTH-1:0]  drop_cnt2,
    output logic [CNT_WIDTH-1:0]  drop_cnt3,
    output logic [CNT_WIDTH-1:0]  drop_cnt4,
`endif
    output logic [1:0]            out_ch
);

    localparam int              IDX_W    = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {HUNT, FILL, DROP} asm_t;
    typedef enum logic       {IDLE, SEND}       sch_t;

    logic [DATA_WIDTH-1:0] in_data [4];
    logic                  in_vld  [4];

    asm_t                  asm_st    [4];
    asm_t                  asm_nx    [4];
    logic [IDX_W-1:0]      wr_idx    [4];
    logic [IDX_W-1:0]      wr_idx_nx [4];
    logic                  wr_en     [4];
    logic                  full_set  [4];
    logic                  drop_done [4];
    logic [3:0]            full;
    logic [3:0]            clr_mask;
    logic [DATA_WIDTH-1:0] pkt_buf [4][PKT_LEN];

    sch_t                  sch_st, sch_nx;
    logic [1:0]            rr_ptr;
    logic [1:0]            grant, cand;
    logic                  grant_vld;
    logic                  accept, finish;
    logic [IDX_W-1:0]      rd_idx, rd_nx;

    assign in_data[0] = rdata1;
    assign in_data[1] = rdata2;
    assign in_data[2] = rdata3;
    assign in_data[3] = rdata4;
    assign in_vld[0]  = valid_out1;
    assign in_vld[1]  = valid_out2;
    assign in_vld[2]  = valid_out3;
    assign in_vld[3]  = valid_out4;

    // Input stage: per-channel packet assemblers
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            asm_nx[c]    = asm_st[c];
            wr_idx_nx[c] = wr_idx[c];
            wr_en[c]     = 1'b0;
            full_set[c]  = 1'b0;
            drop_done[c] = 1'b0;
            if (in_vld[c]) begin
                case (asm_st[c])
                    HUNT: begin
                        if (in_data[c] == SYNC_BYTE) begin
                            wr_idx_nx[c] = IDX_W'(1);
                            // An occupied buffer (including one mid-send) forces a drop.
                            if (full[c]) begin
                                asm_nx[c] = DROP;
                            end else begin
                                wr_en[c]  = 1'b1;
                                asm_nx[c] = FILL;
                            end
                        end
                    end
                    FILL: begin
                        wr_en[c] = 1'b1;
                        if (wr_idx[c] == LAST_IDX) begin
                            asm_nx[c]    = HUNT;
                            wr_idx_nx[c] = '0;
                            full_set[c]  = 1'b1;
                        end else begin
                            wr_idx_nx[c] = wr_idx[c] + IDX_W'(1);
                        end
                    end
                    DROP: begin
                        if (wr_idx[c] == LAST_IDX) begin
                            asm_nx[c]    = HUNT;
                            wr_idx_nx[c] = '0;
                            drop_done[c] = 1'b1;
                        end else begin
                            wr_idx_nx[c] = wr_idx[c] + IDX_W'(1);
                        end
                    end
                    default: begin
                        asm_nx[c]    = HUNT;
                        wr_idx_nx[c] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int c = 0; c < 4; c++) begin
                asm_st[c] <= HUNT;
                wr_idx[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                asm_st[c] <= asm_nx[c];
                wr_idx[c] <= wr_idx_nx[c];
            end
        end
    end

    always_ff @(posedge rclk) begin
        for (int c = 0; c < 4; c++) begin
            if (wr_en[c]) pkt_buf[c][wr_idx[c]] <= in_data[c];
        end
    end

    // Set and clear never target the same channel in one cycle: a channel
    // being sent is full and therefore cannot be filling.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            full <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (full_set[c])      full[c] <= 1'b1;
                else if (clr_mask[c]) full[c] <= 1'b0;
            end
        end
    end

    // Output stage: round-robin scheduler
    assign rd_nx  = rd_idx + IDX_W'(1);
    assign accept = out_valid & out_ready;

    always_comb begin
        sch_nx    = sch_st;
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        finish    = 1'b0;
        clr_mask  = '0;
        // Descending scan so the candidate closest to rr_ptr wins.
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (full[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
        case (sch_st)
            IDLE: if (grant_vld) sch_nx = SEND;
            SEND: begin
                if (accept && out_eop) begin
                    sch_nx           = IDLE;
                    finish           = 1'b1;
                    clr_mask[out_ch] = 1'b1;
                end
            end
            default: sch_nx = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) sch_st <= IDLE;
        else      sch_st <= sch_nx;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rr_ptr    <= '0;
            rd_idx    <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            case (sch_st)
                IDLE: begin
                    if (grant_vld) begin
                        out_ch    <= grant;
                        rr_ptr    <= grant + 2'd1;
                        rd_idx    <= '0;
                        out_data  <= pkt_buf[grant][0];
                        out_valid <= 1'b1;
                        out_sop   <= 1'b1;
                        out_eop   <= 1'b0;
                    end
                end
                SEND: begin
                    if (finish) begin
                        out_valid <= 1'b0;
                        out_sop   <= 1'b0;
                        out_eop   <= 1'b0;
                    end else if (accept) begin
                        rd_idx   <= rd_nx;
                        out_data <= pkt_buf[out_ch][rd_nx];
                        out_sop  <= 1'b0;
                        out_eop  <= (rd_nx == LAST_IDX);
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

`ifdef QOS_STATS_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [CNT_WIDTH-1:0] drop_cnt [4];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int c = 0; c < 4; c++) drop_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (drop_done[c]) drop_cnt[c] <= sat_inc(drop_cnt[c]);
            end
        end
    end

    assign drop_cnt1 = drop_cnt[0];
    assign drop_cnt2 = drop_cnt[1];
    assign drop_cnt3 = drop_cnt[2];
    assign drop_cnt4 = drop_cnt[3];
`else
    logic unused_drop;
    assign unused_drop = &{1'b0, drop_done[0], drop_done[1], drop_done[2], drop_done[3], CNT_WIDTH[0]};
`endif

endmodule
